// File: rtl/uart_serdes.sv
// 8N1 UART serdes: valid/ack byte in -> tx pin; rx pin -> one-cycle data/error strobes. Ack is combinational in IDLE.
// TX frame spans 10N+1 cycles per accepted byte; RX strobes ~9.5N+2 cycles after the start edge, no backpressure.
module uart_serdes #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   output logic       o_tx,
   input  logic       i_rx,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_data_valid,
   output logic       o_tx_data_ack,
   output logic       o_tx_busy,
   output logic [7:0] o_rx_data,
   output logic       o_rx_data_valid,
   output logic       o_rx_frame_error,
   output logic       o_rx_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

   tx_state_t       r_tx_state;
   logic [CW-1:0]   r_tx_cnt;
   logic [2:0]      r_tx_idx;
   logic [7:0]      r_tx_shift;
   logic            r_tx;

   rx_state_t       r_rx_state;
   logic [CW-1:0]   r_rx_cnt;
   logic [2:0]      r_rx_idx;
   logic [7:0]      r_rx_shift;
   logic            r_rx_meta;
   logic            r_rxs;
   logic [7:0]      r_rx_data;
   logic            r_rx_data_valid;
   logic            r_rx_frame_error;

   logic            w_tx_ack;

   assign w_tx_ack         = (r_tx_state == TX_IDLE) & i_tx_data_valid & ~i_rst;
   assign o_tx_data_ack    = w_tx_ack;
   assign o_tx             = r_tx;
   assign o_tx_busy        = (r_tx_state != TX_IDLE);
   assign o_rx_data        = r_rx_data;
   assign o_rx_data_valid  = r_rx_data_valid;
   assign o_rx_frame_error = r_rx_frame_error;
   assign o_rx_busy        = (r_rx_state != RX_IDLE);

   // tx holds the bit being sent; the shift register is pre-shifted so bit 0 is always next.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_shift <= '0;
         r_tx       <= 1'b1;
      end else begin
         case (r_tx_state)
            TX_IDLE: begin
               r_tx <= 1'b1;
               if (w_tx_ack) begin
                  r_tx_shift <= i_tx_data;
                  r_tx_cnt   <= '0;
                  r_tx       <= 1'b0;
                  r_tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (r_tx_cnt == LAST) begin
                  r_tx_cnt   <= '0;
                  r_tx_idx   <= '0;
                  r_tx       <= r_tx_shift[0];
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  r_tx_state <= TX_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            TX_DATA: begin
               if (r_tx_cnt == LAST) begin
                  r_tx_cnt <= '0;
                  if (r_tx_idx == 3'd7) begin
                     r_tx       <= 1'b1;
                     r_tx_state <= TX_STOP;
                  end else begin
                     r_tx_idx   <= r_tx_idx + 3'd1;
                     r_tx       <= r_tx_shift[0];
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            TX_STOP: begin
               if (r_tx_cnt == LAST) begin
                  r_tx_cnt   <= '0;
                  r_tx_state <= TX_IDLE;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 1'b1;
               end
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_meta <= 1'b1;
         r_rxs     <= 1'b1;
      end else begin
         r_rx_meta <= i_rx;
         r_rxs     <= r_rx_meta;
      end
   end

   // Half-bit wait in START puts every later sample at mid-bit.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_state       <= RX_IDLE;
         r_rx_cnt         <= '0;
         r_rx_idx         <= '0;
         r_rx_shift       <= '0;
         r_rx_data        <= '0;
         r_rx_data_valid  <= 1'b0;
         r_rx_frame_error <= 1'b0;
      end else begin
         r_rx_data_valid  <= 1'b0;
         r_rx_frame_error <= 1'b0;
         case (r_rx_state)
            RX_IDLE: begin
               if (!r_rxs) begin
                  r_rx_cnt   <= '0;
                  r_rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (r_rx_cnt == HALF) begin
                  r_rx_cnt   <= '0;
                  r_rx_idx   <= '0;
                  r_rx_state <= r_rxs ? RX_IDLE : RX_DATA;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_rx_cnt == LAST) begin
                  r_rx_cnt   <= '0;
                  r_rx_shift <= {r_rxs, r_rx_shift[7:1]};
                  r_rx_idx   <= r_rx_idx + 3'd1;
                  if (r_rx_idx == 3'd7) r_rx_state <= RX_STOP;
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_rx_cnt == LAST) begin
                  r_rx_cnt <= '0;
                  if (r_rxs) begin
                     r_rx_data       <= r_rx_shift;
                     r_rx_data_valid <= 1'b1;
                     r_rx_state      <= RX_IDLE;
                  end else begin
                     r_rx_frame_error <= 1'b1;
                     r_rx_state       <= RX_WAIT_HIGH;
                  end
               end else begin
                  r_rx_cnt <= r_rx_cnt + 1'b1;
               end
            end
            RX_WAIT_HIGH: if (r_rxs) r_rx_state <= RX_IDLE;
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_serdes.sv
// Self-checking bench for uart_serdes: scoreboard queues for TX line decode and RX strobes.
module tb_uart_serdes;
   localparam int N = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx;
   logic       rx_drv = 1'b1;
   logic       loop = 1'b0;
   logic       rx_pin;
   logic [7:0] tx_data = 8'h00;
   logic       tx_vld = 1'b0;
   logic       tx_ack;
   logic       tx_busy;
   logic [7:0] rx_data;
   logic       rx_vld;
   logic       rx_ferr;
   logic       rx_busy;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         exp_ferr = 0;
   bit         mon_en = 1'b1;
   logic [7:0] txq[$];
   logic [7:0] rxq[$];

   assign rx_pin = loop ? tx : rx_drv;

   uart_serdes #(.CLKS_PER_BIT(N)) dut (
      .i_clk(clk), .i_rst(rst), .o_tx(tx), .i_rx(rx_pin),
      .i_tx_data(tx_data), .i_tx_data_valid(tx_vld), .o_tx_data_ack(tx_ack),
      .o_tx_busy(tx_busy), .o_rx_data(rx_data), .o_rx_data_valid(rx_vld),
      .o_rx_frame_error(rx_ferr), .o_rx_busy(rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // TX line decoder: samples mid-bit from the detected falling edge.
   initial begin : tx_mon
      logic       prev;
      logic [7:0] got;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && prev && !tx) begin
            repeat (N/2 - 1) @(negedge clk);
            check("tx_start_mid", tx, 0);
            for (int k = 0; k < 8; k++) begin
               repeat (N) @(negedge clk);
               got[k] = tx;
            end
            repeat (N) @(negedge clk);
            check("tx_stop_bit", tx, 1);
            if (txq.size() == 0) check("tx_unexpected_frame", 1, 0);
            else check("tx_byte", got, txq.pop_front());
         end
         prev = tx;
      end
   end

   always @(negedge clk) begin
      if (rx_vld) begin
         if (rxq.size() == 0) check("rx_unexpected_strobe", 1, 0);
         else check("rx_byte", rx_data, rxq.pop_front());
      end
      if (rx_ferr) begin
         check("rx_ferr_expected", exp_ferr, 1);
         if (exp_ferr > 0) exp_ferr--;
      end
   end

   task automatic send_tx(input logic [7:0] b[4], input int n);
      int i = 0;
      int t = 0;
      int last = 0;
      @(posedge clk); #1;
      tx_data = b[0];
      tx_vld  = 1'b1;
      while (i < n && t < 12*N*n + 50) begin
         @(negedge clk);
         t++;
         if (tx_ack) begin
            txq.push_back(b[i]);
            if (loop) rxq.push_back(b[i]);
            if (i > 0) check("tx_ack_gap", cyc - last, 10*N + 1);
            last = cyc;
            i++;
            @(posedge clk); #1;
            if (i < n) tx_data = b[i];
            else tx_vld = 1'b0;
         end
      end
      tx_vld = 1'b0;
      check("tx_ack_count", i, n);
   endtask

   task automatic rx_send(input logic [7:0] b, input int cpb, input bit stop);
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (cpb) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         rx_drv = b[k];
         repeat (cpb) @(negedge clk);
      end
      rx_drv = stop;
      repeat (cpb) @(negedge clk);
      if (stop) rx_drv = 1'b1;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((txq.size() != 0 || rxq.size() != 0 || exp_ferr != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", txq.size() + rxq.size() + exp_ferr, 0);
      repeat (N) @(negedge clk);
   endtask

   initial begin
      bit [9:0] frame;
      int       ok[10];

      // Reset state, with valid offered to prove ack is gated by reset
      tx_vld = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_tx_ack", tx_ack, 0);
      check("rst_tx_busy", tx_busy, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_vld", rx_vld, 0);
      check("rst_rx_ferr", rx_ferr, 0);
      check("rst_rx_busy", rx_busy, 0);
      tx_vld = 1'b0;
      rst    = 1'b0;
      repeat (4) @(negedge clk);

      // Single 0xA5 with per-cycle bit width checks
      @(posedge clk); #1;
      tx_data = 8'hA5;
      tx_vld  = 1'b1;
      @(negedge clk);
      check("a5_ack", tx_ack, 1);
      txq.push_back(8'hA5);
      @(posedge clk); #1;
      tx_vld = 1'b0;
      frame = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) ok[k] = 0;
      for (int c = 1; c <= 10*N + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check("a5_ack_once", tx_ack, 0);
            check("a5_busy_first", tx_busy, 1);
         end
         if (c <= 10*N && tx == frame[(c-1)/N]) ok[(c-1)/N]++;
         if (c == 10*N) check("a5_busy_last", tx_busy, 1);
         if (c == 10*N + 1) begin
            check("a5_busy_clear", tx_busy, 0);
            check("a5_tx_idle", tx, 1);
         end
      end
      for (int k = 0; k < 10; k++) check($sformatf("a5_bit%0d_width", k), ok[k], N);
      wait_done(200);

      // Back-to-back burst
      send_tx('{8'hAA, 8'h34, 8'h12, 8'h55}, 4);
      wait_done(400);

      // Loopback
      loop = 1'b1;
      send_tx('{8'h00, 8'hFF, 8'h3C, 8'h00}, 3);
      wait_done(400);
      loop = 1'b0;

      // Short glitch must not start a frame
      @(negedge clk);
      rx_drv = 1'b0;
      repeat (4) @(negedge clk);
      rx_drv = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_rx_busy", rx_busy, 0);
      check("glitch_rx_data", rx_data, 8'h3C);

      // Framing error, then a break, then a good frame
      exp_ferr = 1;
      rx_send(8'h5A, N, 1'b0);
      repeat (300) @(negedge clk);
      check("ferr_busy_in_break", rx_busy, 1);
      rx_drv = 1'b1;
      wait_done(100);
      check("ferr_rx_data_held", rx_data, 8'h3C);
      rxq.push_back(8'h81);
      rx_send(8'h81, N, 1'b1);
      wait_done(200);

      // Baud skew
      rxq.push_back(8'hC3);
      rx_send(8'hC3, N - 1, 1'b1);
      wait_done(200);
      rxq.push_back(8'hC3);
      rx_send(8'hC3, N + 1, 1'b1);
      wait_done(200);

      // Reset mid TX frame
      mon_en = 1'b0;
      @(posedge clk); #1;
      tx_data = 8'h99;
      tx_vld  = 1'b1;
      @(negedge clk);
      check("rstmid_tx_ack_pre", tx_ack, 1);
      repeat (50) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rstmid_tx", tx, 1);
      check("rstmid_tx_ack", tx_ack, 0);
      check("rstmid_tx_busy", tx_busy, 0);
      @(negedge clk);
      check("rstmid_tx_ack_hold", tx_ack, 0);
      tx_vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Reset during RX data bit 4
      fork
         rx_send(8'h99, N, 1'b1);
         begin
            repeat (88) @(negedge clk);
            check("rstmid_rx_busy_pre", rx_busy, 1);
            rst = 1'b1;
            #1;
            check("rstmid_rx_busy", rx_busy, 0);
            check("rstmid_rx_data", rx_data, 0);
            check("rstmid_rx_vld", rx_vld, 0);
            check("rstmid_rx_ferr", rx_ferr, 0);
         end
      join
      repeat (10) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Clean restart
      mon_en = 1'b1;
      loop   = 1'b1;
      send_tx('{8'h7E, 8'h00, 8'h00, 8'h00}, 1);
      wait_done(400);
      check("final_rx_data", rx_data, 8'h7E);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_serdes.md
# uart_serdes

8N1 UART serializer/deserializer sitting directly downstream of the frame-counter packet shifter: it accepts bytes over a valid/ack handshake and drives them onto the `tx` pin. It also deserializes bytes from the `rx` pin into single-cycle strobes. Clocked from the 1.8432 MHz UART clock; the default divider gives 115200 baud.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per bit; must be an even number ≥ 4.
- `clk` in 1: UART clock, 1.8432 MHz; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tx` out 1: serial output; idle high.
- `rx` in 1: serial input; asynchronous to `clk`.
- `tx_data` in 8: byte to send; must be stable while `tx_data_valid` is high.
- `tx_data_valid` in 1: `tx_data` is offered.
- `tx_data_ack` out 1: combinational; the byte is accepted on this edge.
- `tx_busy` out 1: transmitter is not in IDLE.
- `rx_data` out 8: last received byte; holds its value between strobes.
- `rx_data_valid` out 1: one-cycle strobe when `rx_data` is updated.
- `rx_frame_error` out 1: one-cycle strobe when the stop bit is sampled low.
- `rx_busy` out 1: receiver is not in IDLE.

## Operation
- **Reset values**: `tx`=1, `tx_busy`=0, `rx_data`=0x00, `rx_data_valid`=0, `rx_frame_error`=0, `rx_busy`=0. `tx_data_ack` is forced to 0 while `rst` is high. The two `rx` synchronizer flops reset to 1.
- **Frame format**: start bit (0), data bits d0 first through d7, one stop bit (1). No parity.
- **TX states**: IDLE → START → DATA → STOP → IDLE.
  - `tx_data_ack` = IDLE & `tx_data_valid` & ~`rst`.
  - On ack, `tx_data` is latched into the shift register and the state moves to START.
  - A bit counter (`$clog2(CLKS_PER_BIT)` bits) counts 0..CLKS_PER_BIT-1 in each of START, DATA and STOP.
  - A 3-bit index counts data bits 0..7.
  - `tx` is registered and equals the current bit; it is 1 in IDLE and STOP.
  - On the last cycle of STOP the state returns to IDLE.
  - A byte is never accepted outside IDLE.
- **RX front end**: `rx` passes through a 2-flop synchronizer, giving `rxs`. All RX decisions use `rxs`.
- **RX states**: IDLE → START → DATA → STOP → (IDLE | WAIT_HIGH).
  - IDLE: `rxs`=0 moves to START with the counter cleared.
  - START: at count CLKS_PER_BIT/2-1, re-sample. If `rxs`=1 the start is a glitch and the state returns to IDLE with no strobe. If `rxs`=0, go to DATA with the counter cleared.
  - DATA: sample `rxs` at count CLKS_PER_BIT-1, i.e. mid-bit, and shift into bit 7 of an 8-bit shift register (LSB arrives first). After 8 samples, go to STOP.
  - STOP: sample at count CLKS_PER_BIT-1.
    - If `rxs`=1: `rx_data` is loaded from the shift register, `rx_data_valid` pulses, and the state returns to IDLE.
    - If `rxs`=0: `rx_frame_error` pulses, `rx_data` is unchanged, and the state goes to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs`=1, then go to IDLE. This keeps a break condition from being decoded as repeated 0x00 frames.
- **Independence**: TX and RX are fully independent; they may be active simultaneously.
- **Reset mid-frame**: reset aborts any frame immediately and returns all outputs to their reset values. The receiver restarts cleanly on the next falling edge after reset.

## Timing
- **TX acceptance**: the ack edge is cycle 0. `tx` goes low from cycle 1. The start bit occupies cycles 1..N, where N = CLKS_PER_BIT.
  - Data bit k occupies cycles 1+(k+1)N .. (k+2)N.
  - The stop bit occupies cycles 1+9N .. 10N.
  - IDLE is reached at cycle 10N+1.
- **Back-to-back TX**: with `tx_data_valid` held high, the next ack lands at cycle 10N+1. Each frame therefore spans 10N+1 cycles (the stop bit is N+1 cycles). At N=16 this is 161 cycles.
- **`tx_busy`**: 1 from cycle 1 through cycle 10N.
- **RX latency**: the first `rxs` low edge is at +2 cycles from the `rx` fall. `rx_data_valid` asserts about 9.5N+2 cycles after the `rx` falling edge.
- **RX tolerance**: samples are taken mid-bit, giving ±N/2 cycles of accumulated drift tolerance per frame.

## Test plan
- **Single TX byte**: `tx_data`=0xA5, valid for 1 cycle in IDLE → ack for 1 cycle. `tx` reads 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles wide. `tx_busy` falls at cycle 161.
- **Packet burst**: bytes 0xAA, 0x34, 0x12, 0x55 offered back-to-back with valid held → exactly 4 acks, spaced 161 cycles apart. The serial stream decodes to the same byte order. There is no idle gap beyond the one extra stop cycle.
- **RX loopback**: `tx` is tied to `rx` and bytes 0x00, 0xFF, 0x3C are sent → three `rx_data_valid` strobes with matching `rx_data` and no `rx_frame_error`.
- **RX glitch and framing error**:
  - A 4-cycle low pulse on `rx` → no strobe, and `rx_busy` returns to 0.
  - A frame 0x5A with its stop bit low and `rx` held low for 300 cycles → one `rx_frame_error` and no `rx_data_valid`. `rx_data` keeps its prior value. The next good frame 0x81 is received correctly.
- **Baud skew**: RX stimulus at CLKS_PER_BIT ±6% (15 and 17 cycles per bit) → byte 0xC3 is received correctly in both cases.
- **Reset mid-frame**: `rst` asserted at cycle 50 of a TX frame and during RX data bit 4 → `tx`=1, `tx_data_ack`=0 while `rst` is high, and all outputs take their reset values immediately. After release, a fresh 0x7E is transmitted and received correctly.
